// File: rtl/any1_pkg.sv
// rtl/any1_pkg.sv - shared types, fault causes and lane helpers for the ANY-1 memory interface
package any1_pkg;

   typedef enum logic [1:0] {
      BYTE  = 2'd0,
      WYDE  = 2'd1,
      TETRA = 2'd2,
      OCTA  = 2'd3
   } memsz_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC1 = 2'd1,
      ACC2 = 2'd2,
      DONE = 2'd3
   } memif_state_t;

   localparam logic [1:0] FLT_NONE  = 2'd0;
   localparam logic [1:0] FLT_ALIGN = 2'd1;
   localparam logic [1:0] FLT_TMO   = 2'd2;
   localparam logic [1:0] FLT_BERR  = 2'd3;

   // Byte-lane mask over two octas: low byte is the first access, high byte the second.
   function automatic logic [15:0] lane_mask(input logic [2:0] off, input logic [1:0] sz);
      logic [15:0] base;
      case (sz)
         2'd0:    base = 16'h0001;
         2'd1:    base = 16'h0003;
         2'd2:    base = 16'h000F;
         default: base = 16'h00FF;
      endcase
      return base << off;
   endfunction

   // Right-justified store data moved onto its byte lanes across two octas.
   function automatic logic [127:0] store_shift(input logic [63:0] d, input logic [2:0] off);
      return {64'd0, d} << {off, 3'b000};
   endfunction

   // True when the offset is not a multiple of the access width.
   function automatic logic misaligned(input logic [2:0] off, input logic [1:0] sz);
      case (sz)
         2'd0:    return 1'b0;
         2'd1:    return off[0];
         2'd2:    return |off[1:0];
         default: return |off;
      endcase
   endfunction

endpackage

// File: rtl/any1_load_align.sv
// rtl/any1_load_align.sv - shifts a two-octa load buffer down, truncates to size and extends
module any1_load_align
   import any1_pkg::*;
(
   input  logic [127:0] buffer,
   input  logic [2:0]   off,
   input  logic [1:0]   sz,
   input  logic         sx,
   output logic [63:0]  res
);

   logic [63:0] s;

   assign s = 64'(buffer >> {off, 3'b000});

   // Truncate to the access width, then sign- or zero-extend; octa passes through.
   always_comb begin
      res = s;
      case (memsz_t'(sz))
         BYTE:    res = {{56{sx & s[7]}},  s[7:0]};
         WYDE:    res = {{48{sx & s[15]}}, s[15:0]};
         TETRA:   res = {{32{sx & s[31]}}, s[31:0]};
         default: res = s;
      endcase
   end

endmodule

// File: rtl/any1_memif.sv
// rtl/any1_memif.sv - ANY-1 load/store bus master; ANY1_MEMIF_UNALIGNED_EN splits octa-crossing accesses
module any1_memif
   import any1_pkg::*;
#(
   parameter int AWID = 32,
   parameter int TMO  = 255
) (
   input  logic            rst,
   input  logic            clk,
   input  logic            req,
   output logic            rdy,
   input  logic            we,
   input  logic [1:0]      sz,
   input  logic            sx,
   input  logic [AWID-1:0] ea,
   input  logic [63:0]     dat,
   output logic            done,
   output logic [63:0]     res,
   output logic            fault,
   output logic [1:0]      fcause,
   output logic            cyc_o,
   output logic            stb_o,
   output logic            we_o,
   output logic [7:0]      sel_o,
   output logic [AWID-1:0] adr_o,
   output logic [63:0]     dat_o,
   input  logic            ack_i,
   input  logic            err_i,
   input  logic [63:0]     dat_i
);

   memif_state_t state;
   memsz_t       sz_q;
   logic [2:0]   off_q;
   logic         sx_q;
   logic         we_q;
   logic [7:0]   cnt;
   logic [7:0]   sel_in;
   logic [63:0]  wdat_in;
   logic [127:0] buf_next;
   logic [63:0]  ld_res;
   logic         cnt_hit;
   logic         fin_ok;
   logic         fin_flt;
   logic [1:0]   cause;

`ifdef ANY1_MEMIF_UNALIGNED_EN
   logic [15:0]  mask_full;
   logic [127:0] wdat_full;
   logic         split_q;
   logic [7:0]   sel_hi_q;
   logic [63:0]  dat_hi_q;
   logic [63:0]  buf_lo;
   logic         go_acc2;

   assign mask_full = lane_mask(ea[2:0], sz);
   assign wdat_full = store_shift(dat, ea[2:0]);
   assign sel_in    = mask_full[7:0];
   assign wdat_in   = wdat_full[63:0];
   // The second octa's data lands above the first one captured in ACC1.
   assign buf_next  = (state == ACC2) ? {dat_i, buf_lo} : {64'd0, dat_i};
`else
   logic mis_in;

   assign sel_in   = 8'(lane_mask(ea[2:0], sz));
   assign wdat_in  = 64'(store_shift(dat, ea[2:0]));
   assign mis_in   = misaligned(ea[2:0], sz);
   assign buf_next = {64'd0, dat_i};
`endif

   assign cnt_hit = (cnt + 8'd1) == 8'(TMO);

   any1_load_align u_align (
      .buffer (buf_next),
      .off    (off_q),
      .sz     (sz_q),
      .sx     (sx_q),
      .res    (ld_res)
   );

   // Resolve the outcome of a live strobe: error beats ack, ack beats timeout.
   always_comb begin
      fin_ok  = 1'b0;
      fin_flt = 1'b0;
      cause   = FLT_NONE;
`ifdef ANY1_MEMIF_UNALIGNED_EN
      go_acc2 = 1'b0;
`endif
      if ((state == ACC1 || state == ACC2) && stb_o) begin
         if (err_i) begin
            fin_flt = 1'b1;
            cause   = FLT_BERR;
         end else if (ack_i) begin
`ifdef ANY1_MEMIF_UNALIGNED_EN
            if (state == ACC1 && split_q)
               go_acc2 = 1'b1;
            else
`endif
               fin_ok = 1'b1;
         end else if (cnt_hit) begin
            fin_flt = 1'b1;
            cause   = FLT_TMO;
         end
      end
   end

   // Access sequencer with registered bus controls and completion outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rdy    <= 1'b1;
         done   <= 1'b0;
         res    <= '0;
         fault  <= 1'b0;
         fcause <= FLT_NONE;
         cyc_o  <= 1'b0;
         stb_o  <= 1'b0;
         we_o   <= 1'b0;
         sel_o  <= '0;
         adr_o  <= '0;
         dat_o  <= '0;
         cnt    <= '0;
         sz_q   <= BYTE;
         off_q  <= '0;
         sx_q   <= 1'b0;
         we_q   <= 1'b0;
`ifdef ANY1_MEMIF_UNALIGNED_EN
         split_q  <= 1'b0;
         sel_hi_q <= '0;
         dat_hi_q <= '0;
         buf_lo   <= '0;
`endif
      end else begin
         done   <= 1'b0;
         fault  <= 1'b0;
         fcause <= FLT_NONE;
         res    <= '0;
         case (state)
            IDLE: begin
               if (req) begin
                  we_q  <= we;
                  sz_q  <= memsz_t'(sz);
                  sx_q  <= sx;
                  off_q <= ea[2:0];
                  cnt   <= 8'd0;
                  rdy   <= 1'b0;
`ifdef ANY1_MEMIF_UNALIGNED_EN
                  split_q  <= |mask_full[15:8];
                  sel_hi_q <= mask_full[15:8];
                  dat_hi_q <= wdat_full[127:64];
`else
                  if (mis_in) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     fault  <= 1'b1;
                     fcause <= FLT_ALIGN;
                  end else
`endif
                  begin
                     state <= ACC1;
                     cyc_o <= 1'b1;
                     stb_o <= 1'b1;
                     we_o  <= we;
                     sel_o <= sel_in;
                     adr_o <= {ea[AWID-1:3], 3'b000};
                     dat_o <= wdat_in;
                  end
               end
            end
            ACC1, ACC2: begin
               if (fin_ok || fin_flt) begin
                  state  <= DONE;
                  cyc_o  <= 1'b0;
                  stb_o  <= 1'b0;
                  we_o   <= 1'b0;
                  sel_o  <= '0;
                  adr_o  <= '0;
                  dat_o  <= '0;
                  done   <= 1'b1;
                  fault  <= fin_flt;
                  fcause <= cause;
                  res    <= (fin_ok && !we_q) ? ld_res : 64'd0;
               end
`ifdef ANY1_MEMIF_UNALIGNED_EN
               else if (go_acc2) begin
                  state  <= ACC2;
                  stb_o  <= 1'b0;
                  cnt    <= 8'd0;
                  buf_lo <= dat_i;
                  sel_o  <= sel_hi_q;
                  dat_o  <= dat_hi_q;
                  adr_o  <= adr_o + AWID'(8);
               end else if (!stb_o) begin
                  stb_o <= 1'b1;
               end
`endif
               else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               rdy   <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_any1_memif.sv
// tb/tb_any1_memif.sv - scoreboard bench for any1_memif with a byte-level memory model
module tb_any1_memif;
   localparam int AWID = 32;
   localparam int TMO  = 4;
`ifdef ANY1_MEMIF_UNALIGNED_EN
   localparam bit UA = 1'b1;
`else
   localparam bit UA = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        req   = 1'b0;
   logic        we    = 1'b0;
   logic [1:0]  sz    = 2'd0;
   logic        sx    = 1'b0;
   logic [31:0] ea    = '0;
   logic [63:0] dat   = '0;
   logic        ack_i = 1'b0;
   logic        err_i = 1'b0;
   logic [63:0] dat_i = '0;
   logic        rdy, done, fault, cyc_o, stb_o, we_o;
   logic [63:0] res, dat_o;
   logic [1:0]  fcause;
   logic [7:0]  sel_o;
   logic [31:0] adr_o;

   any1_memif #(.AWID(AWID), .TMO(TMO)) dut (
      .rst(rst), .clk(clk), .req(req), .rdy(rdy), .we(we), .sz(sz), .sx(sx),
      .ea(ea), .dat(dat), .done(done), .res(res), .fault(fault), .fcause(fcause),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
      .dat_o(dat_o), .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] res;
      logic        fault;
      logic [1:0]  cause;
      int          lat;
      int          gaps;
      int          stbn;
      int          cycn;
   } exp_t;

   typedef struct {
      logic [31:0] adr;
      logic [7:0]  sel;
      logic        we;
      logic [63:0] dat;
   } beat_t;

   exp_t        exp_q[$];
   beat_t       beat_q[$];
   logic [63:0] mem [logic [31:0]];

   int checks = 0;
   int errors = 0;
   int rmode  = 0;
   int rwait  = 0;
   int wcnt   = 0;
   int cycn   = 0;
   int t_req  = 0;
   int stb_n  = 0;
   int gap_n  = 0;
   int cyc_n  = 0;
   int done_n = 0;
   exp_t        me;
   beat_t       rb;
   logic [63:0] rw;
   logic [63:0] m64;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   function automatic logic [63:0] rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {~a, a};
   endfunction

   always @(posedge clk) cycn++;

   // Bus responder: acks after rwait strobe cycles, checks each beat, applies stores.
   always @(negedge clk) begin
      ack_i = 1'b0;
      err_i = 1'b0;
      if (cyc_o && stb_o && !rst) begin
         if (rmode == 2) begin
            ack_i = 1'b1;
            err_i = 1'b1;
         end else if (rmode == 0) begin
            if (wcnt >= rwait) begin
               ack_i = 1'b1;
               dat_i = rd(adr_o);
               wcnt  = 0;
               chk("beat_expected", beat_q.size() != 0, 1);
               if (beat_q.size() != 0) begin
                  rb = beat_q.pop_front();
                  chk("adr_o", adr_o, rb.adr);
                  chk("sel_o", sel_o, rb.sel);
                  chk("we_o", we_o, rb.we);
                  if (rb.we) begin
                     rw  = rd(adr_o);
                     m64 = '0;
                     for (int i = 0; i < 8; i++) begin
                        if (sel_o[i]) begin
                           m64[i*8 +: 8] = 8'hFF;
                           rw[i*8 +: 8]  = dat_o[i*8 +: 8];
                        end
                     end
                     chk("dat_o", dat_o & m64, rb.dat);
                     mem[adr_o] = rw;
                  end
               end
            end else begin
               wcnt++;
            end
         end
      end else begin
         wcnt = 0;
      end
   end

   // Completion monitor: per-transaction bus statistics and scoreboard pop on done.
   always @(negedge clk) begin
      if (!rst) begin
         if (req && rdy) begin
            t_req = cycn;
            stb_n = 0;
            gap_n = 0;
            cyc_n = 0;
         end
         if (cyc_o) cyc_n++;
         if (cyc_o && stb_o) stb_n++;
         if (cyc_o && !stb_o) gap_n++;
         if (done) begin
            done_n++;
            chk("done_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               me = exp_q.pop_front();
               chk("res", res, me.res);
               chk("fault", fault, me.fault);
               chk("fcause", fcause, me.cause);
               chk("latency", cycn - t_req, me.lat);
               chk("stb_gaps", gap_n, me.gaps);
               chk("stb_cycles", stb_n, me.stbn);
               chk("cyc_cycles", cyc_n, me.cycn);
               chk("done_cyc_low", cyc_o, 0);
               chk("done_rdy_low", rdy, 0);
            end
         end
      end
   end

   task automatic start(input logic w, input logic [1:0] s, input logic x, input logic [31:0] a,
                        input logic [63:0] d, input int mode, input int wt);
      exp_t        e;
      beat_t       b [2];
      int          n, nb, k;
      logic [31:0] ba;
      logic [63:0] wv;
      n       = 1 << s;
      e.res   = '0;
      e.fault = 1'b0;
      e.cause = 2'd0;
      e.gaps  = 0;
      if (!UA && (int'(a[2:0]) % n) != 0) begin
         e.fault = 1'b1; e.cause = 2'd1; e.lat = 1; e.stbn = 0; e.cycn = 0;
      end else if (mode == 1) begin
         e.fault = 1'b1; e.cause = 2'd2; e.lat = 1 + TMO; e.stbn = TMO; e.cycn = TMO;
      end else if (mode == 2) begin
         e.fault = 1'b1; e.cause = 2'd3; e.lat = 2; e.stbn = 1; e.cycn = 1;
      end else begin
         nb = 1;
         for (int j = 0; j < 2; j++) begin
            b[j].adr = {a[31:3], 3'b000} + 32'(8 * j);
            b[j].sel = '0;
            b[j].we  = w;
            b[j].dat = '0;
         end
         for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            k  = (ba[31:3] != a[31:3]) ? 1 : 0;
            if (k == 1) nb = 2;
            b[k].sel[ba[2:0]]          = 1'b1;
            b[k].dat[ba[2:0]*8 +: 8]   = d[i*8 +: 8];
            wv                         = rd({ba[31:3], 3'b000});
            e.res[i*8 +: 8]            = wv[ba[2:0]*8 +: 8];
         end
         if (w)
            e.res = '0;
         else if (x && n < 8 && e.res[n*8-1])
            e.res = e.res | (~64'd0 << (n * 8));
         e.lat  = (nb == 2) ? 4 + 2 * wt : 2 + wt;
         e.gaps = nb - 1;
         e.stbn = nb * (1 + wt);
         e.cycn = e.lat - 1;
         for (int j = 0; j < nb; j++) beat_q.push_back(b[j]);
      end
      rmode = mode;
      rwait = wt;
      exp_q.push_back(e);
      @(posedge clk); #1;
      req = 1'b1; we = w; sz = s; sx = x; ea = a; dat = d;
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic txn(input logic w, input logic [1:0] s, input logic x, input logic [31:0] a,
                      input logic [63:0] d, input int mode, input int wt);
      int n0;
      n0 = done_n;
      start(w, s, x, a, d, mode, wt);
      for (int i = 0; i < 60 && done_n == n0; i++) @(posedge clk);
      chk("done_seen", done_n, n0 + 1);
      @(posedge clk);
   endtask

   initial begin
      int n0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rdy", rdy, 1);
      chk("rst_cyc", cyc_o, 0);
      chk("rst_stb", stb_o, 0);
      chk("rst_done", done, 0);
      chk("rst_res", res, 0);
      chk("rst_sel", sel_o, 0);
      chk("rst_adr", adr_o, 0);
      chk("rst_fault", fault, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      mem[32'h100] = 64'h1122334455667788;
      mem[32'h200] = 64'h0000000080000000;
      txn(1'b0, 2'd3, 1'b0, 32'h100, 64'd0, 0, 0);
      txn(1'b0, 2'd0, 1'b1, 32'h203, 64'd0, 0, 0);
      txn(1'b0, 2'd0, 1'b0, 32'h203, 64'd0, 0, 0);
      txn(1'b1, 2'd2, 1'b0, 32'h306, 64'hAABBCCDD, 0, 0);
      txn(1'b0, 2'd2, 1'b1, 32'h304, 64'd0, 0, 0);
      txn(1'b0, 2'd1, 1'b1, 32'h10A, 64'd0, 0, 2);
      txn(1'b0, 2'd2, 1'b0, 32'h120, 64'd0, 0, TMO - 1);
      txn(1'b0, 2'd2, 1'b0, 32'h400, 64'd0, 1, 0);
      txn(1'b0, 2'd3, 1'b0, 32'h408, 64'd0, 2, 0);

      rmode = 1;
      n0    = done_n;
      @(posedge clk); #1;
      req = 1'b1; we = 1'b0; sz = 2'd3; ea = 32'h500;
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      chk("acc1_stb", stb_o, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_cyc", cyc_o, 0);
      chk("mid_rst_stb", stb_o, 0);
      chk("mid_rst_rdy", rdy, 1);
      repeat (5) @(posedge clk);
      chk("mid_rst_no_done", done_n, n0);

      for (int r = 0; r < 40; r++) begin
         txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'h1000 + 32'($urandom_range(0, 31)), {$urandom, $urandom}, 0,
             int'($urandom_range(0, 2)));
      end

      chk("beats_left", beat_q.size(), 0);
      chk("exp_left", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/any1_memif.md
# any1_memif

Load/store bus master for the ANY-1 core. It consumes the registered effective address produced by address generation, plus size, direction and store data. It runs one or two classic Wishbone-style bus cycles and returns aligned, sign- or zero-extended load data or a store completion. It sits between the memory stage and the external data bus, and is the responder half of the address-generation → memory handshake.

## Interface
- AWID, 32, address width
- TMO, 255, bus-cycle timeout in clocks (8-bit counter)
- rst  in  1  synchronous, active-high reset
- clk  in  1  single clock; all logic on rising edge
- req  in  1  request strobe; accepted when req && rdy
- rdy  out  1  high when idle and able to accept
- we  in  1  1 = store, 0 = load
- sz  in  2  0 byte, 1 wyde, 2 tetra, 3 octa
- sx  in  1  sign-extend load result
- ea  in  AWID  byte effective address
- dat  in  64  store data, right-justified
- done  out  1  one-cycle completion pulse
- res  out  64  load result; valid with done; 0 for stores
- fault  out  1  pulses with done on failure
- fcause  out  2  0 none, 1 misalign, 2 timeout, 3 bus error
- cyc_o, stb_o, we_o  out  1  bus controls
- sel_o  out  8  byte lanes
- adr_o  out  AWID  octa-aligned address, low 3 bits 0
- dat_o  out  64  write data
- ack_i, err_i  in  1  bus acknowledge / error
- dat_i  in  64  read data

## Operation
- States: IDLE, ACC1, ACC2, DONE.
- IDLE: rdy = 1. On req, latch we/sz/sx/ea/dat, then go to ACC1.
- Byte offset off = ea[2:0]; width n = 1<<sz bytes.
- Lane mask m[15:0] = ((1<<n)-1) << off.
- Store data is shifted left by off*8 into 128 bits. ACC1 uses mask/data low halves; ACC2 uses the high halves.
- adr_o = {ea[AWID-1:3],3'b0} in ACC1, plus 8 in ACC2. Wrap at 2^AWID is silent.
- ACC1 → ACC2 when m[15:8] != 0, otherwise → DONE.
- Load data: dat_i is captured into a 128-bit buffer on each ack. The result is buffer >> (off*8), truncated to n bytes and then extended per sx. Octa loads ignore sx.
- err_i sampled with or without ack: abort to DONE with fcause 3. err_i has priority over ack_i in the same cycle.
- Timeout: a counter clears at entry to each ACC state. If it reaches TMO without ack/err, abort with fcause 2.
- DONE: pulse done (plus fault/fcause), then go to IDLE. On fault, res = 0.
- req while not rdy is ignored and not queued.

## Timing
- Reset values: rdy 1; all other outputs 0; state IDLE; counter 0.
- Cycle t: req accepted. At t+1: cyc_o/stb_o/we_o/sel_o/adr_o/dat_o registered high/valid.
- Ack sampled at edge k: stb_o drops at k+1.
  - For ACC2, cyc_o stays high, stb_o is low for exactly one cycle, then re-asserts at k+2.
- done asserted the cycle after the final ack. Minimum latency is req→done = 2 clocks for a single access with zero-wait ack.
- rdy is low from t+1 through the done cycle; it rises the cycle after done.
- cyc_o drops in the done cycle.
- Reset mid-transaction: bus outputs cleared at the next edge; no done pulse; any late ack is ignored.

## Configuration
- ANY1_MEMIF_UNALIGNED_EN defined: accesses crossing an octa boundary split into ACC1+ACC2 as above.
- Undefined: any access with off not a multiple of n skips the bus (no cyc_o). DONE is reached at t+1 with fault=1, fcause=1. ACC2 logic is not built.

## Structure
- The shared any1_pkg holds:
  - memsz_t enum (BYTE, WYDE, TETRA, OCTA)
  - memif_state_t enum
  - fault-cause constants FLT_NONE/FLT_ALIGN/FLT_TMO/FLT_BERR
- Sub-module any1_load_align: combinational 128-bit shift, truncate and sign/zero extend. Inputs: buffer, off, sz, sx. Output: res.

## Test plan
- Load octa, ea=0x100, ack same cycle, dat_i=0x1122334455667788 → adr_o=0x100, sel_o=0xFF, done at t+2, res=0x1122334455667788.
- Load byte sx=1, ea=0x203, dat_i byte3=0x80 → sel_o=0x08, res=0xFFFFFFFFFFFFFF80. With sx=0 → res=0x80.
- Store tetra, ea=0x306, dat=0xAABBCCDD, macro defined → two cycles:
  - adr 0x300, sel 0xC0, dat_o[63:48]=0xCCDD
  - then adr 0x308, sel 0x03, dat_o[15:0]=0xAABB
  - one stb-low cycle between; single done.
- Same store with macro undefined → no cyc_o; done+fault at t+1; fcause=1.
- Load with ack never returned, TMO=4 → stb_o held 4 cycles, then done, fault, fcause=2, res=0.
- err_i and ack_i together on ACC1 → fcause=3. Separately, rst asserted during ACC1 → next cycle cyc_o=0, rdy=1, no done.
